i2c_mem_burst: RTL

Parametrised I2C master/slave memory pair: the next generation of our single-byte I2C memory block, generalised in address width, data width, memory depth and burst length. An internal master serialises requests from a parallel host port onto an internal SDA/SCL pair. An internal slave owns a DEPTH-word memory, auto-increments the word address across a burst, and NACKs out-of-range addresses. It sits between the UVM host agent and the I2C bus model, and is the DUT for the burst-mode I2C environment.

---
 rtl/i2c_mem_burst.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_mem_burst.sv
// Burst I2C memory pair: a host-side master serialises parallel requests onto an
// internal SDA/SCL pair; a slave owns a DEPTH-word memory with auto-incrementing pointer.
module i2c_mem_burst #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 128,
  parameter int MAX_BURST = 4,
  localparam int LEN_W    = $clog2(MAX_BURST) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              done,
  output logic              nack,
  output logic [3:0]        dbg_mst_state,
  output logic [2:0]        dbg_slv_state,
  output logic              dbg_scl,
  output logic              dbg_sda
);
  localparam int CNT_MAX = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(DEPTH - 1);
  localparam logic [LEN_W-1:0]  BURST_L = LEN_W'(MAX_BURST);

  typedef enum logic [3:0] {M_IDLE, M_START, M_ADDR, M_AACK, M_WR_WAIT, M_WR_BYTE,
                            M_WR_ACK, M_RD_BYTE, M_RD_ACK, M_STOP} mst_t;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_AACK, S_WR_BIT, S_WR_ACK, S_RD_BIT,
                            S_RD_ACK} slv_t;

  mst_t mst, mst_nxt;
  slv_t slv, slv_nxt;
  logic scl, sda, sda_m, sda_s;
  logic rw_q, nack_q, last_word;
  logic [ADDR_W:0]     afr, asr;
  logic [LEN_W-1:0]    rem, len_c;
  logic [CNT_W-1:0]    mcnt, scnt;
  logic [DATA_W-1:0]   wsh, rsh, swr, srd;
  logic [ADDR_W-1:0]   ptr, ptr_inc, s_addr;
  logic                s_rw, s_ack;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Wired-AND bus; only the master drives SCL.
  assign sda = sda_m & sda_s;
  assign dbg_scl = scl;
  assign dbg_sda = sda;
  assign dbg_mst_state = mst;
  assign dbg_slv_state = slv;

  assign busy      = (mst != M_IDLE);
  assign last_word = (rem == LEN_W'(1));

  always_comb begin
    len_c = len;
    if (len == '0) len_c = LEN_W'(1);
    else if (len > BURST_L) len_c = BURST_L;
  end

  // Host write handshake: a word moves when din_valid && din_ready in the same cycle;
  // din_ready is only raised when the master is about to start shifting a new word.
  always_comb begin
    din_ready = 1'b0;
    case (mst)
      M_AACK:    din_ready = !sda && rw_q && din_valid;
      M_WR_WAIT: din_ready = din_valid;
      M_WR_ACK:  din_ready = !last_word && din_valid;
      default:   din_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) mst <= M_IDLE;
    else     mst <= mst_nxt;
  end

  always_comb begin
    mst_nxt = mst;
    case (mst)
      M_IDLE:    if (start) mst_nxt = M_START;
      M_START:   mst_nxt = M_ADDR;
      M_ADDR:    if (mcnt == CNT_W'(ADDR_W)) mst_nxt = M_AACK;
      M_AACK:    if (sda) mst_nxt = M_STOP;
                 else if (rw_q) mst_nxt = din_valid ? M_WR_BYTE : M_WR_WAIT;
                 else mst_nxt = M_RD_BYTE;
      M_WR_WAIT: if (din_valid) mst_nxt = M_WR_BYTE;
      M_WR_BYTE: if (mcnt == CNT_W'(DATA_W - 1)) mst_nxt = M_WR_ACK;
      M_WR_ACK:  if (last_word) mst_nxt = M_STOP;
                 else mst_nxt = din_valid ? M_WR_BYTE : M_WR_WAIT;
      M_RD_BYTE: if (mcnt == CNT_W'(DATA_W - 1)) mst_nxt = M_RD_ACK;
      M_RD_ACK:  mst_nxt = last_word ? M_STOP : M_RD_BYTE;
      M_STOP:    mst_nxt = M_IDLE;
      default:   mst_nxt = M_IDLE;
    endcase
  end

  // STOP is signalled as SCL=0/SDA=0, which a stretch (SCL=0/SDA=1) never produces.
  always_comb begin
    scl   = 1'b1;
    sda_m = 1'b1;
    case (mst)
      M_START:   sda_m = 1'b0;
      M_ADDR:    sda_m = afr[0];
      M_WR_WAIT: scl   = 1'b0;
      M_WR_BYTE: sda_m = wsh[0];
      M_RD_ACK:  sda_m = last_word;
      M_STOP:    begin scl = 1'b0; sda_m = 1'b0; end
      default:   sda_m = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q <= 1'b0; nack_q <= 1'b0; afr <= '0; rem <= '0; mcnt <= '0;
      wsh <= '0; rsh <= '0; dout <= '0; dout_valid <= 1'b0; done <= 1'b0; nack <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      done       <= (mst == M_STOP);
      nack       <= (mst == M_STOP) && nack_q;
      mcnt       <= (mst_nxt != mst) ? '0 : mcnt + 1'b1;
      case (mst)
        M_IDLE: if (start) begin
          rw_q <= wr; afr <= {addr, wr}; rem <= len_c; nack_q <= 1'b0;
        end
        M_ADDR:    afr <= afr >> 1;
        M_AACK:    nack_q <= sda;
        M_WR_BYTE: wsh <= wsh >> 1;
        M_RD_BYTE: begin
          rsh <= {sda, rsh[DATA_W-1:1]};
          if (mcnt == CNT_W'(DATA_W - 1)) begin
            dout       <= {sda, rsh[DATA_W-1:1]};
            dout_valid <= 1'b1;
          end
        end
        M_WR_ACK, M_RD_ACK: rem <= rem - 1'b1;
        default: ;
      endcase
      if (din_ready) wsh <= din;
    end
  end

  assign s_addr  = asr[ADDR_W:1];
  assign s_rw    = asr[0];
  assign s_ack   = ({1'b0, s_addr} < DEPTH_L);
  assign ptr_inc = (ptr == PTR_MAX) ? '0 : ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) slv <= S_IDLE;
    else     slv <= slv_nxt;
  end

  always_comb begin
    slv_nxt = slv;
    case (slv)
      S_IDLE:   if (scl && !sda) slv_nxt = S_ADDR;
      S_ADDR:   if (scl && scnt == CNT_W'(ADDR_W)) slv_nxt = S_AACK;
      S_AACK:   if (!s_ack) slv_nxt = S_IDLE;
                else slv_nxt = s_rw ? S_WR_BIT : S_RD_BIT;
      S_WR_BIT: if (!scl) begin
                  if (!sda) slv_nxt = S_IDLE;
                end else if (scnt == CNT_W'(DATA_W - 1)) slv_nxt = S_WR_ACK;
      S_WR_ACK: slv_nxt = S_WR_BIT;
      S_RD_BIT: if (scnt == CNT_W'(DATA_W - 1)) slv_nxt = S_RD_ACK;
      S_RD_ACK: slv_nxt = sda ? S_IDLE : S_RD_BIT;
      default:  slv_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sda_s = 1'b1;
    case (slv)
      S_AACK:   sda_s = !s_ack;
      S_WR_ACK: sda_s = 1'b0;
      S_RD_BIT: sda_s = srd[0];
      default:  sda_s = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asr <= '0; ptr <= '0; scnt <= '0; swr <= '0; srd <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      scnt <= (slv_nxt != slv) ? '0 : (scl ? scnt + 1'b1 : scnt);
      case (slv)
        S_ADDR:   asr <= {sda, asr[ADDR_W:1]};
        S_AACK:   begin
          ptr <= s_addr;
          if (s_ack) srd <= mem[s_addr];
        end
        S_WR_BIT: if (scl) swr <= {sda, swr[DATA_W-1:1]};
        S_WR_ACK: begin mem[ptr] <= swr; ptr <= ptr_inc; end
        S_RD_BIT: srd <= srd >> 1;
        S_RD_ACK: if (!sda) begin ptr <= ptr_inc; srd <= mem[ptr_inc]; end
        default: ;
      endcase
    end
  end
endmodule
